msg_streamer: RTL and testbench
===============================

# msg_streamer

Synthesizable, parametrised successor to the hello-world message printer. It stores a fixed character string and, on a start pulse, streams it one character per transfer over a valid/ready byte interface. It can repeat the message a programmable number of times with a programmable idle gap between repetitions, and supports abort. It sits between the control logic and a character sink (UART TX, display FIFO or testbench monitor).

## Interface
- DATA_W, 8: character width in bits.
- MSG_LEN, 13: number of characters in the message (≥1).
- MSG, "Hello, World!": packed MSG_LEN*DATA_W-bit string. Character 0 is in the most significant DATA_W bits.
- REP_W, 4: width of the repeat-count input.
- GAP_W, 8: width of the gap input.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a stream; sampled only in IDLE.
- abort  in  1  terminate the current stream at the next edge.
- rep_cnt  in  REP_W  number of repetitions minus 1 (0 = one emission); latched on accepted start.
- gap  in  GAP_W  idle cycles between repetitions; latched on accepted start.
- out_data  out  DATA_W  current character.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts; a transfer occurs on an edge with out_valid & out_ready.
- out_last  out  1  out_data is the last character of the current repetition. Qualified by out_valid.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse after the final transfer of the final repetition.

## Operation
- FSM states are IDLE, SEND and GAP. All outputs are registered.
- Reset: state = IDLE. out_valid, out_last, busy and done are 0, out_data is 0, and the character index, repetition counter and gap counter are 0.
- IDLE:
  - start=1 and abort=0 latches rep_cnt and gap, sets char_idx=0 and rep_left=rep_cnt, and moves to SEND.
  - start=1 with abort=1 in the same cycle is ignored.
- SEND: out_valid=1 and out_data=MSG[char_idx].
  - On a transfer with char_idx<MSG_LEN-1: char_idx increments.
  - On a transfer with char_idx=MSG_LEN-1:
    - rep_left=0: go to IDLE and pulse done.
    - rep_left>0 and gap=0: rep_left decrements, char_idx=0, stay in SEND. out_valid stays high with no bubble.
    - rep_left>0 and gap>0: rep_left decrements, gap counter is loaded with gap, go to GAP.
- GAP: out_valid=0. The counter decrements each cycle. When it reaches 1, the next state is SEND with char_idx=0, giving exactly `gap` idle cycles.
- Handshake rule: while out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid does not drop.
- abort=1 in SEND or GAP: next cycle is IDLE with out_valid=0 and busy=0. done is not pulsed and a pending character is discarded.
- start while busy is ignored; there is no queueing.
- rst has priority over abort and start.
- rst asserted mid-stream forces the reset values at the next edge. No done pulse is produced.
- Width rules:
  - char_idx has width $clog2(MSG_LEN), minimum 1.
  - The repetition counter is REP_W bits and does not wrap, because it stops at 0.
  - The total number of repetitions is rep_cnt+1, with a maximum of 2^REP_W.

## Timing
- start accepted at edge k: out_valid=1 with character 0 from cycle k+1. busy rises in the same cycle.
- With out_ready held at 1, one repetition takes MSG_LEN consecutive transfer cycles.
- A full run of R=rep_cnt+1 repetitions with gap G keeps busy high for R·MSG_LEN + (R−1)·G cycles.
- done is high for exactly one cycle, the cycle after the final transfer. In that cycle busy=0 and out_valid=0.
- A new start is accepted in the same cycle done is high. The first character then appears one cycle later.
- out_last=1 exactly when char_idx=MSG_LEN-1 in SEND.

## Test plan
- Basic run: reset, start with rep_cnt=0 and gap=0, out_ready=1.
  - Expect 13 transfers "H","e",…,"!" (0x48 … 0x21) on consecutive cycles.
  - out_last is high only on 0x21.
  - done pulses one cycle after, and busy is high for 13 cycles.
- Backpressure: out_ready toggles in a 1010 pattern, then is held 0 for 5 cycles mid-message.
  - out_data is stable while stalled and all 13 characters arrive in order.
  - No character is dropped or duplicated.
- Repeat with gap: rep_cnt=2, gap=3.
  - Expect 3 messages with exactly 3 idle cycles between them.
  - busy is high for 3·13+2·3=45 cycles, and done pulses once.
- Back-to-back: rep_cnt=1, gap=0.
  - Expect 26 continuous transfers with out_valid never low, and out_last high twice.
- Abort and reset: abort during character 5 of repetition 0.
  - out_valid=0 and busy=0 next cycle, and there is no done pulse.
  - Then assert rst during GAP of another run: all outputs return to their reset values next cycle.
- Start edge cases:
  - start asserted while busy has no effect.
  - start with abort in IDLE is ignored.
  - start in the done cycle restarts with "H" one cycle later.
  - Parameter override MSG_LEN=2, MSG="OK" streams 0x4F, 0x4B.

Source files
------------

// File: rtl/msg_streamer_if.sv
// Byte-stream interface between the message streamer, its controller and the character sink.
// master is the streamer side; slave is the controller/sink side.
interface msg_streamer_if #(
    parameter int DATA_W = 8,
    parameter int REP_W  = 4,
    parameter int GAP_W  = 8
);
    logic              start;
    logic              abort;
    logic [REP_W-1:0]  rep_cnt;
    logic [GAP_W-1:0]  gap;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, rep_cnt, gap, out_ready,
        output out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, abort, rep_cnt, gap, out_ready,
        input  out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/msg_streamer.sv
// Streams a fixed character string over a valid/ready byte interface, with programmable
// repetition count, idle gap between repetitions, and abort. All outputs are registered.
module msg_streamer #(
    parameter int                        DATA_W  = 8,
    parameter int                        MSG_LEN = 13,
    parameter logic [MSG_LEN*DATA_W-1:0] MSG     = "Hello, World!",
    parameter int                        REP_W   = 4,
    parameter int                        GAP_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    msg_streamer_if.master bus
);
    localparam int               IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(MSG_LEN - 1);
    localparam logic             ONE_CHAR = (MSG_LEN == 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  char_idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [REP_W-1:0]  rep_left;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;

    // Character 0 lives in the most significant DATA_W bits of MSG.
    function automatic logic [DATA_W-1:0] msg_char(input logic [IDX_W-1:0] idx);
        return MSG[(MSG_LEN - 1 - int'(idx)) * DATA_W +: DATA_W];
    endfunction

    assign idx_nxt = char_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            char_idx      <= '0;
            rep_left      <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state         <= SEND;
                        rep_left      <= bus.rep_cnt;
                        gap_q         <= bus.gap;
                        char_idx      <= '0;
                        bus.out_data  <= msg_char('0);
                        bus.out_last  <= ONE_CHAR;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state         <= IDLE;
                        char_idx      <= '0;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else if (bus.out_ready) begin
                        if (char_idx != LAST) begin
                            char_idx     <= idx_nxt;
                            bus.out_data <= msg_char(idx_nxt);
                            bus.out_last <= (idx_nxt == LAST);
                        end else if (rep_left == '0) begin
                            state         <= IDLE;
                            char_idx      <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else if (gap_q == '0) begin
                            // Wrap straight back to character 0 so valid never drops.
                            rep_left     <= rep_left - REP_W'(1);
                            char_idx     <= '0;
                            bus.out_data <= msg_char('0);
                            bus.out_last <= ONE_CHAR;
                        end else begin
                            state         <= GAP;
                            rep_left      <= rep_left - REP_W'(1);
                            gap_cnt       <= gap_q;
                            char_idx      <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (gap_cnt == GAP_W'(1)) begin
                        // Leaving on count 1 yields exactly gap idle cycles.
                        state         <= SEND;
                        char_idx      <= '0;
                        bus.out_data  <= msg_char('0);
                        bus.out_last  <= ONE_CHAR;
                        bus.out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_streamer.sv
// Self-checking bench for msg_streamer: a flattened slot-list model of the stream is
// compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_msg_streamer;
    logic clk;
    logic rst;

    msg_streamer_if #(.DATA_W(8), .REP_W(4), .GAP_W(8)) bus ();
    msg_streamer_if #(.DATA_W(8), .REP_W(4), .GAP_W(8)) bus2 ();

    msg_streamer #(.DATA_W(8), .MSG_LEN(13), .MSG("Hello, World!"), .REP_W(4), .GAP_W(8))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    msg_streamer #(.DATA_W(8), .MSG_LEN(2), .MSG("OK"), .REP_W(4), .GAP_W(8))
        u_ok (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                               8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the whole run is a list of slots, char index or -1 for an idle gap cycle.
    int  seq [$];
    int  pos = 0;
    bit  m_active = 0;
    bit  m_done = 0;
    logic [7:0] exp_log [$];

    initial begin
        forever begin
            @(posedge clk);
            m_done = 0;
            if (rst) begin
                m_active = 0;
            end else if (m_active) begin
                if (bus.abort) begin
                    m_active = 0;
                end else if (seq[pos] < 0) begin
                    pos++;
                end else if (bus.out_ready) begin
                    exp_log.push_back(hello[seq[pos]]);
                    pos++;
                    if (pos == seq.size()) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end
            end else if (bus.start && !bus.abort) begin
                seq.delete();
                for (int r = 0; r <= int'(bus.rep_cnt); r++) begin
                    for (int i = 0; i < 13; i++) seq.push_back(i);
                    if (r < int'(bus.rep_cnt))
                        for (int g = 0; g < int'(bus.gap); g++) seq.push_back(-1);
                end
                pos = 0;
                m_active = 1;
            end
        end
    end

    // Per-cycle comparison and run statistics, sampled on the falling edge.
    bit en_cmp = 0;
    int busy_cyc = 0, done_cyc = 0, gap_cyc = 0, last_cnt = 0;
    logic [7:0] dut_log [$];
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (en_cmp) begin
                bit ev;
                ev = m_active && (seq[pos] >= 0);
                chk("valid", 32'(bus.out_valid), 32'(ev));
                chk("busy", 32'(bus.busy), 32'(m_active));
                chk("done", 32'(bus.done), 32'(m_done));
                if (ev) begin
                    chk("data", 32'(bus.out_data), 32'(hello[seq[pos]]));
                    chk("last", 32'(bus.out_last), 32'(seq[pos] == 12));
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_data", 32'(bus.out_data), 32'(prev_data));
                end
                prev_stall = bus.out_valid && !bus.out_ready && !bus.abort && !rst;
                prev_data  = bus.out_data;
                if (bus.busy) busy_cyc++;
                if (bus.done) done_cyc++;
                if (bus.busy && !bus.out_valid) gap_cyc++;
                if (bus.out_valid && bus.out_ready && !bus.abort && !rst) begin
                    dut_log.push_back(bus.out_data);
                    if (bus.out_last) last_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        busy_cyc = 0; done_cyc = 0; gap_cyc = 0; last_cnt = 0;
        dut_log.delete();
        exp_log.delete();
    endtask

    task automatic run_start(input int rc, input int g);
        bus.rep_cnt = 4'(rc);
        bus.gap     = 8'(g);
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("wait_bound", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
        chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
    endtask

    task automatic chk_log(input string tag, input int n);
        chk({tag, "_len"}, 32'(dut_log.size()), 32'(n));
        chk({tag, "_mlen"}, 32'(exp_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({tag, "_char"}, 32'(dut_log[i]), 32'(hello[i % 13]));
            chk({tag, "_mchar"}, 32'(exp_log[i]), 32'(hello[i % 13]));
        end
    endtask

    logic rdy_pat [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.rep_cnt = '0; bus.gap = '0; bus.out_ready = 1'b1;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.rep_cnt = '0; bus2.gap = '0; bus2.out_ready = 1'b1;
        tick();
        en_cmp = 1;
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Basic run
        clr();
        run_start(0, 0);
        wait_idle(100);
        tick();
        chk("basic_busy_cycles", 32'(busy_cyc), 32'd13);
        chk("basic_done_count", 32'(done_cyc), 32'd1);
        chk("basic_last_count", 32'(last_cnt), 32'd1);
        chk_log("basic", 13);

        // Backpressure
        clr();
        run_start(0, 0);
        for (int i = 0; i < 11; i++) begin
            bus.out_ready = rdy_pat[i];
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle(100);
        tick();
        chk("bp_done_count", 32'(done_cyc), 32'd1);
        chk_log("bp", 13);

        // Repeat with gap
        clr();
        run_start(2, 3);
        wait_idle(200);
        tick();
        chk("rep_busy_cycles", 32'(busy_cyc), 32'd45);
        chk("rep_gap_cycles", 32'(gap_cyc), 32'd6);
        chk("rep_done_count", 32'(done_cyc), 32'd1);
        chk("rep_last_count", 32'(last_cnt), 32'd3);
        chk_log("rep", 39);

        // Back-to-back
        clr();
        run_start(1, 0);
        wait_idle(200);
        tick();
        chk("b2b_busy_cycles", 32'(busy_cyc), 32'd26);
        chk("b2b_gap_cycles", 32'(gap_cyc), 32'd0);
        chk("b2b_last_count", 32'(last_cnt), 32'd2);
        chk_log("b2b", 26);

        // Abort during character 5
        clr();
        run_start(0, 0);
        repeat (5) tick();
        chk("abort_pre_data", 32'(bus.out_data), 32'h2C);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        chk("abort_done_count", 32'(done_cyc), 32'd0);
        chk("abort_len", 32'(dut_log.size()), 32'd5);

        // Reset during gap
        clr();
        run_start(1, 5);
        repeat (14) tick();
        chk("gap_state_valid", 32'(bus.out_valid), 32'd0);
        chk("gap_state_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_vals("rst_gap");
        rst = 1'b0;
        tick();
        tick();
        chk("rst_gap_done_count", 32'(done_cyc), 32'd0);

        // Start while busy is ignored
        clr();
        run_start(0, 0);
        repeat (3) tick();
        bus.rep_cnt = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle(200);
        tick();
        chk("busy_start_cycles", 32'(busy_cyc), 32'd13);
        chk("busy_start_done", 32'(done_cyc), 32'd1);

        // Start together with abort in IDLE is ignored
        bus.rep_cnt = 4'd0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", 32'(bus.busy), 32'd0);
        chk("start_abort_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("start_abort_busy2", 32'(bus.busy), 32'd0);

        // Restart in the done cycle
        clr();
        run_start(0, 0);
        wait_idle(100);
        chk("restart_done_now", 32'(bus.done), 32'd1);
        run_start(0, 0);
        chk("restart_valid", 32'(bus.out_valid), 32'd1);
        chk("restart_data", 32'(bus.out_data), 32'h48);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        wait_idle(100);
        tick();
        chk("restart_done_count", 32'(done_cyc), 32'd2);

        // Two-character override instance
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        chk("ok_valid0", 32'(bus2.out_valid), 32'd1);
        chk("ok_data0", 32'(bus2.out_data), 32'h4F);
        chk("ok_last0", 32'(bus2.out_last), 32'd0);
        tick();
        chk("ok_data1", 32'(bus2.out_data), 32'h4B);
        chk("ok_last1", 32'(bus2.out_last), 32'd1);
        tick();
        chk("ok_done", 32'(bus2.done), 32'd1);
        chk("ok_valid_end", 32'(bus2.out_valid), 32'd0);
        chk("ok_busy_end", 32'(bus2.busy), 32'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
